// File: rtl/param_fifo.sv
// Synchronous FIFO with registered count, level flags and overflow/underflow pulses.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output (read latency 0).
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, underflow_q;
    logic          wr_acc, rd_acc;

    // Acceptance uses the flags from the previous edge, so a full FIFO
    // can still read and an empty FIFO can still write in the same cycle.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr && full;
            underflow_q <= rd && empty;
        end
    end

    // Storage is never cleared; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q] <= data_in;
    end

`ifdef PARAM_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (rst)         data_out_q <= '0;
        else if (rd_acc) data_out_q <= mem[rd_ptr_q];
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at default parameters (WIDTH=8, DEPTH=32, AF=28, AE=4).
// Works in both standard and PARAM_FIFO_FWFT_EN builds.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [5:0] count;
    logic       overflow, underflow;

    int vec  = 0;
    int miss = 0;

    param_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one clock cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr = w; data_in = d; rd = r;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns the word delivered by a read (head before the edge in FWFT, registered output after it otherwise).
    task automatic pop(input logic w, input logic [7:0] d, output logic [7:0] got);
`ifdef PARAM_FIFO_FWFT_EN
        got = data_out;
        cyc(w, d, 1'b1);
`else
        cyc(w, d, 1'b1);
        got = data_out;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec++; if (empty !== 1'b1)        begin miss++; $display("FAIL reset_empty: got %b want 1", empty); end
        vec++; if (almost_empty !== 1'b1) begin miss++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
        vec++; if (full !== 1'b0)         begin miss++; $display("FAIL reset_full: got %b want 0", full); end
        vec++; if (almost_full !== 1'b0)  begin miss++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        vec++; if (count !== 6'd0)        begin miss++; $display("FAIL reset_count: got %0d want 0", count); end
        vec++; if (data_out !== 8'h00)    begin miss++; $display("FAIL reset_dout: got %h want 00", data_out); end
        vec++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin miss++; $display("FAIL reset_pulses: got ovf=%b udf=%b want 0 0", overflow, underflow); end
        $display("test_reset: done");
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            vec++; if (count !== 6'(i)) begin miss++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            vec++; if (almost_full !== (i >= 28)) begin miss++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i >= 28)); end
            vec++; if (full !== (i == 32)) begin miss++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 32)); end
            vec++; if (almost_empty !== (i <= 4)) begin miss++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, almost_empty, (i <= 4)); end
            vec++; if (empty !== 1'b0) begin miss++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
        end
        $display("test_fill: 32 writes");
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        cyc(1'b1, 8'hAA, 1'b0);
        vec++; if (overflow !== 1'b1) begin miss++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        vec++; if (count !== 6'd32)   begin miss++; $display("FAIL ovf_count: got %0d want 32", count); end
        cyc(1'b0, 8'h00, 1'b0);
        vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
        for (int i = 1; i <= 32; i++) begin
            pop(1'b0, 8'h00, got);
            vec++; if (got !== 8'(i)) begin miss++; $display("FAIL drain[%0d]: got %h want %h", i, got, 8'(i)); end
        end
        vec++; if (empty !== 1'b1) begin miss++; $display("FAIL drain_empty: got %b want 1", empty); end
        $display("test_overflow: 0xAA rejected, 32 reads");
    endtask

    task automatic test_underflow();
        cyc(1'b0, 8'h00, 1'b1);
        vec++; if (underflow !== 1'b1) begin miss++; $display("FAIL udf_pulse: got %b want 1", underflow); end
        vec++; if (count !== 6'd0)     begin miss++; $display("FAIL udf_count: got %0d want 0", count); end
`ifndef PARAM_FIFO_FWFT_EN
        vec++; if (data_out !== 8'h20) begin miss++; $display("FAIL udf_dout: got %h want 20", data_out); end
`endif
        cyc(1'b0, 8'h00, 1'b0);
        vec++; if (underflow !== 1'b0) begin miss++; $display("FAIL udf_one_cycle: got %b want 0", underflow); end
        $display("test_underflow: done");
    endtask

    task automatic test_wrap();
        logic [7:0] got;
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 30; i++) begin
            pop(1'b0, 8'h00, got);
            vec++; if (got !== 8'(8'h80 + i)) begin miss++; $display("FAIL wrap_pre[%0d]: got %h want %h", i, got, 8'(8'h80 + i)); end
        end
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h66, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        vec++; if (count !== 6'd3) begin miss++; $display("FAIL wrap_count: got %0d want 3", count); end
        pop(1'b0, 8'h00, got);
        vec++; if (got !== 8'h55) begin miss++; $display("FAIL wrap_rd0: got %h want 55", got); end
        pop(1'b0, 8'h00, got);
        vec++; if (got !== 8'h66) begin miss++; $display("FAIL wrap_rd1: got %h want 66", got); end
        pop(1'b0, 8'h00, got);
        vec++; if (got !== 8'h77) begin miss++; $display("FAIL wrap_rd2: got %h want 77", got); end
        $display("test_wrap: 0x55 0x66 0x77 across pointer wrap");
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        do_reset();
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int k = 0; k < 10; k++) begin
            pop(1'b1, 8'(8'h40 + k), got);
            vec++; if (count !== 6'd16) begin miss++; $display("FAIL b2b_count[%0d]: got %0d want 16", k, count); end
            vec++; if (got !== 8'(k + 1)) begin miss++; $display("FAIL b2b_data[%0d]: got %h want %h", k, got, 8'(k + 1)); end
        end
        for (int j = 0; j < 16; j++) cyc(1'b1, 8'(8'hC0 + j), 1'b0);
        vec++; if (full !== 1'b1) begin miss++; $display("FAIL b2b_full: got %b want 1", full); end
        pop(1'b1, 8'hEE, got);
        vec++; if (count !== 6'd31)   begin miss++; $display("FAIL b2b_full_count: got %0d want 31", count); end
        vec++; if (overflow !== 1'b1) begin miss++; $display("FAIL b2b_full_ovf: got %b want 1", overflow); end
        vec++; if (got !== 8'h0B)     begin miss++; $display("FAIL b2b_full_data: got %h want 0b", got); end
        for (int n = 0; n < 31; n++) begin
            logic [7:0] want;
            if (n < 5)       want = 8'(12 + n);
            else if (n < 15) want = 8'(8'h40 + n - 5);
            else             want = 8'(8'hC0 + n - 15);
            pop(1'b0, 8'h00, got);
            vec++; if (got !== want) begin miss++; $display("FAIL b2b_drain[%0d]: got %h want %h", n, got, want); end
        end
        vec++; if (empty !== 1'b1) begin miss++; $display("FAIL b2b_empty: got %b want 1", empty); end
        $display("test_back_to_back: 10 simultaneous cycles, full wr+rd");
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        pop(1'b0, 8'h00, got);
        rst = 1'b1; wr = 1'b1; data_in = 8'hBB;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        vec++; if (count !== 6'd0)     begin miss++; $display("FAIL rstmid_count: got %0d want 0", count); end
        vec++; if (empty !== 1'b1)     begin miss++; $display("FAIL rstmid_empty: got %b want 1", empty); end
        vec++; if (data_out !== 8'h00) begin miss++; $display("FAIL rstmid_dout: got %h want 00", data_out); end
        vec++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin miss++; $display("FAIL rstmid_pulses: got ovf=%b udf=%b want 0 0", overflow, underflow); end
        cyc(1'b1, 8'h99, 1'b0);
        vec++; if (count !== 6'd1) begin miss++; $display("FAIL rstmid_count1: got %0d want 1", count); end
        pop(1'b0, 8'h00, got);
        vec++; if (got !== 8'h99) begin miss++; $display("FAIL rstmid_data: got %h want 99", got); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
